// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
// Package  : sdram_pkg
// Desc     : Slot phases, client indices and command encodings shared by the
//            SDRAM controller and its upstream arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sdram_pkg;

  // Slot phases as seen by the arbiter
  localparam logic [2:0] PH_GRANT = 3'd7;
  localparam logic [2:0] PH_ACK   = 3'd6;

  // Controller-side phases: ACTIVE at ph0, READ/WRITE at ph2, dout valid after ph5
  localparam logic [2:0] PH_CMD_ACT = 3'd0;
  localparam logic [2:0] PH_CMD_RW  = 3'd2;
  localparam logic [2:0] PH_DOUT    = 3'd5;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;
  localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
  localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
  localparam logic [3:0] CMD_ACTIVE       = 4'b0011;
  localparam logic [3:0] CMD_WRITE        = 4'b0100;
  localparam logic [3:0] CMD_READ         = 4'b0101;
  localparam logic [3:0] CMD_NOP          = 4'b0111;

  typedef enum logic [1:0] {
    CLI_NONE = 2'd0,
    CLI_VID  = 2'd1,
    CLI_CPU  = 2'd2,
    CLI_DMA  = 2'd3
  } client_e;

  // Fixed priority: video > CPU > DMA
  function automatic client_e pick_client(input logic vid, input logic cpu, input logic dma);
    client_e sel;
    sel = CLI_NONE;
    if (vid)
      sel = CLI_VID;
    else if (cpu)
      sel = CLI_CPU;
    else if (dma)
      sel = CLI_DMA;
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_slot_phase.sv
`default_nettype none
// ============================================================================
// Module   : sdram_slot_phase
// Desc     : 3-bit slot phase counter aligned to the 8 MHz chipset clock;
//            identical to the controller's own slot counter.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_slot_phase
  import sdram_pkg::*;
(
  input  logic       clk_64,
  input  logic       reset,
  input  logic       clk_8,
  output logic [2:0] ph,
  output logic       slot_end
);

  logic [2:0] r_ph;
  logic       w_advance;

  // ph7 waits for clk_8 low and ph0 for clk_8 high, locking slot start to clk_8 rising
  always_comb begin
    w_advance = 1'b1;
    if (r_ph == 3'd7)
      w_advance = ~clk_8;
    else if (r_ph == 3'd0)
      w_advance = clk_8;
  end

  always_ff @(posedge clk_64) begin
    if (reset)
      r_ph <= 3'd0;
    else if (w_advance)
      r_ph <= r_ph + 3'd1;
  end

  assign ph       = r_ph;
  assign slot_end = (r_ph == PH_GRANT) && w_advance;

endmodule
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arbiter
// Desc     : Fixed-priority (video > CPU > DMA) one-access-per-slot arbiter in
//            front of the 64 MHz SDRAM controller. Optional macro
//            SDRAM_ARB_REFRESH_SLOT_EN forces periodic idle (refresh) slots.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int AW               = 24,
  parameter int REFRESH_INTERVAL = 8
) (
  input  logic          clk_64,
  input  logic          reset,
  input  logic          clk_8,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [1:0]    cpu_ds,
  input  logic [15:0]   cpu_wdata,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [1:0]    dma_ds,
  input  logic [15:0]   dma_wdata,
  output logic          dma_ack,
  output logic [15:0]   rdata,
  output logic          mem_oe,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [1:0]    mem_ds,
  output logic [15:0]   mem_din,
  input  logic [15:0]   mem_dout
);

  localparam logic [2:0] c_PH_ACK_ARM = PH_ACK - 3'd1;

  logic [2:0]    w_ph;
  logic          w_slot_end;
  client_e       w_pick;
  client_e       w_sel;
  client_e       r_grant;
  client_e       w_grant_nxt;
  logic          r_mem_oe, w_mem_oe_nxt;
  logic          r_mem_we, w_mem_we_nxt;
  logic [AW-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [1:0]    r_mem_ds, w_mem_ds_nxt;
  logic [15:0]   r_mem_din, w_mem_din_nxt;
  logic          r_vid_ack, r_cpu_ack, r_dma_ack;
  logic          w_ack_any;

  sdram_slot_phase u_slot_phase (
    .clk_64   (clk_64),
    .reset    (reset),
    .clk_8    (clk_8),
    .ph       (w_ph),
    .slot_end (w_slot_end)
  );

  assign w_pick = pick_client(vid_req, cpu_req, dma_req);

`ifdef SDRAM_ARB_REFRESH_SLOT_EN
  localparam int                c_SLOT_W    = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(REFRESH_INTERVAL - 1);

  logic [c_SLOT_W-1:0] r_slot_cnt;
  logic                w_force_idle;

  assign w_force_idle = (r_slot_cnt == c_SLOT_LAST);
  assign w_sel        = w_force_idle ? CLI_NONE : w_pick;

  // Any idle slot, forced or natural, already refreshed, so restart the count
  always_ff @(posedge clk_64) begin
    if (reset)
      r_slot_cnt <= '0;
    else if (w_slot_end) begin
      if (w_sel == CLI_NONE)
        r_slot_cnt <= '0;
      else
        r_slot_cnt <= r_slot_cnt + c_SLOT_W'(1);
    end
  end
`else
  assign w_sel = w_pick;
`endif

  always_comb begin
    w_grant_nxt    = r_grant;
    w_mem_oe_nxt   = r_mem_oe;
    w_mem_we_nxt   = r_mem_we;
    w_mem_addr_nxt = r_mem_addr;
    w_mem_ds_nxt   = r_mem_ds;
    w_mem_din_nxt  = r_mem_din;
    if (w_slot_end) begin
      w_grant_nxt    = w_sel;
      w_mem_oe_nxt   = 1'b0;
      w_mem_we_nxt   = 1'b0;
      w_mem_addr_nxt = '0;
      w_mem_ds_nxt   = 2'b00;
      w_mem_din_nxt  = '0;
      case (w_sel)
        CLI_VID: begin
          w_mem_oe_nxt   = 1'b1;
          w_mem_addr_nxt = vid_addr;
          w_mem_ds_nxt   = 2'b11;
        end
        CLI_CPU: begin
          w_mem_oe_nxt   = ~cpu_we;
          w_mem_we_nxt   = cpu_we;
          w_mem_addr_nxt = cpu_addr;
          w_mem_ds_nxt   = cpu_we ? cpu_ds : 2'b11;
          w_mem_din_nxt  = cpu_we ? cpu_wdata : 16'h0000;
        end
        CLI_DMA: begin
          w_mem_oe_nxt   = ~dma_we;
          w_mem_we_nxt   = dma_we;
          w_mem_addr_nxt = dma_addr;
          w_mem_ds_nxt   = dma_we ? dma_ds : 2'b11;
          w_mem_din_nxt  = dma_we ? dma_wdata : 16'h0000;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_64) begin
    if (reset) begin
      r_grant    <= CLI_NONE;
      r_mem_oe   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_ds   <= 2'b00;
      r_mem_din  <= '0;
    end else begin
      r_grant    <= w_grant_nxt;
      r_mem_oe   <= w_mem_oe_nxt;
      r_mem_we   <= w_mem_we_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_mem_ds   <= w_mem_ds_nxt;
      r_mem_din  <= w_mem_din_nxt;
    end
  end

  // ph5 always advances, so each ack is a single-cycle pulse during ph6
  always_ff @(posedge clk_64) begin
    if (reset) begin
      r_vid_ack <= 1'b0;
      r_cpu_ack <= 1'b0;
      r_dma_ack <= 1'b0;
    end else begin
      r_vid_ack <= (w_ph == c_PH_ACK_ARM) && (r_grant == CLI_VID);
      r_cpu_ack <= (w_ph == c_PH_ACK_ARM) && (r_grant == CLI_CPU);
      r_dma_ack <= (w_ph == c_PH_ACK_ARM) && (r_grant == CLI_DMA);
    end
  end

  // Controller dout settles on the same edge that raises ack, so pass it through
  assign w_ack_any = r_vid_ack | r_cpu_ack | r_dma_ack;
  assign rdata     = w_ack_any ? mem_dout : 16'h0000;

  assign vid_ack  = r_vid_ack;
  assign cpu_ack  = r_cpu_ack;
  assign dma_ack  = r_dma_ack;
  assign mem_oe   = r_mem_oe;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_ds   = r_mem_ds;
  assign mem_din  = r_mem_din;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_arbiter
// Desc     : Directed self-checking bench for sdram_arbiter with a small
//            controller read-data model (dout = addr[15:0] ^ 0xACDB after ph5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;
  import sdram_pkg::*;

  localparam int          AW               = 24;
  localparam int          REFRESH_INTERVAL = 4;
  localparam logic [15:0] c_MEM_KEY        = 16'hACDB;

  logic          clk_64 = 1'b0;
  logic          clk_8  = 1'b0;
  logic          reset  = 1'b1;
  logic          vid_req = 1'b0, cpu_req = 1'b0, dma_req = 1'b0;
  logic          cpu_we = 1'b0, dma_we = 1'b0;
  logic [AW-1:0] vid_addr = '0, cpu_addr = '0, dma_addr = '0;
  logic [1:0]    cpu_ds = 2'b00, dma_ds = 2'b00;
  logic [15:0]   cpu_wdata = '0, dma_wdata = '0;
  logic          vid_ack, cpu_ack, dma_ack;
  logic [15:0]   rdata;
  logic          mem_oe, mem_we;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_ds;
  logic [15:0]   mem_din;
  logic [15:0]   mem_dout = 16'h0000;
  logic [2:0]    tb_ph = 3'd0;

  int n_compared   = 0;
  int n_mismatched = 0;

  sdram_arbiter #(
    .AW               (AW),
    .REFRESH_INTERVAL (REFRESH_INTERVAL)
  ) dut (
    .clk_64    (clk_64),
    .reset     (reset),
    .clk_8     (clk_8),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_ack   (vid_ack),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_ds    (cpu_ds),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_ds    (dma_ds),
    .dma_wdata (dma_wdata),
    .dma_ack   (dma_ack),
    .rdata     (rdata),
    .mem_oe    (mem_oe),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_ds    (mem_ds),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  always #8 clk_64 = ~clk_64;

  // clk_8 edges fall between clk_64 edges: 4 high samples then 4 low samples
  initial begin
    #36;
    forever #64 clk_8 = ~clk_8;
  end

  // Reference slot phase and controller read-data model
  always @(posedge clk_64) begin
    if (reset)
      tb_ph <= 3'd0;
    else if ((tb_ph == 3'd7) ? !clk_8 : (tb_ph == 3'd0) ? clk_8 : 1'b1)
      tb_ph <= tb_ph + 3'd1;
    mem_dout <= (tb_ph == 3'd5) ? (mem_addr[15:0] ^ c_MEM_KEY) : 16'h0000;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the next negedge at which the reference phase equals p
  task automatic wait_ph(input logic [2:0] p);
    int n;
    n = 0;
    @(negedge clk_64);
    while (tb_ph != p && n < 40) begin
      @(negedge clk_64);
      n++;
    end
    if (tb_ph != p)
      check_eq("wait_ph_timeout", {29'd0, tb_ph}, {29'd0, p});
  endtask

  // Check one whole slot; at ph6 the owner drops req, or video steps its address
  task automatic run_slot(input string tag, input client_e owner, input logic exp_we,
                          input logic [AW-1:0] exp_addr, input logic [1:0] exp_ds,
                          input logic [15:0] exp_din, input bit keep);
    logic       exp_oe_v, exp_we_v;
    logic [2:0] exp_ack;
    exp_oe_v = (owner != CLI_NONE) && !exp_we;
    exp_we_v = (owner != CLI_NONE) && exp_we;
    case (owner)
      CLI_VID: exp_ack = 3'b100;
      CLI_CPU: exp_ack = 3'b010;
      CLI_DMA: exp_ack = 3'b001;
      default: exp_ack = 3'b000;
    endcase
    for (int p = 0; p < 8; p++) begin
      wait_ph(3'(p));
      check_eq({tag, ".oe"}, {31'd0, mem_oe}, {31'd0, exp_oe_v});
      check_eq({tag, ".we"}, {31'd0, mem_we}, {31'd0, exp_we_v});
      if (owner != CLI_NONE) begin
        check_eq({tag, ".addr"}, {8'd0, mem_addr}, {8'd0, exp_addr});
        check_eq({tag, ".ds"}, {30'd0, mem_ds}, {30'd0, exp_ds});
        if (exp_we)
          check_eq({tag, ".din"}, {16'd0, mem_din}, {16'd0, exp_din});
      end
      if (p == 6) begin
        check_eq({tag, ".ack"}, {29'd0, vid_ack, cpu_ack, dma_ack}, {29'd0, exp_ack});
        if (owner != CLI_NONE && !exp_we)
          check_eq({tag, ".rdata"}, {16'd0, rdata}, {16'd0, exp_addr[15:0] ^ c_MEM_KEY});
        case (owner)
          CLI_VID: if (keep) vid_addr = vid_addr + 1'b1; else vid_req = 1'b0;
          CLI_CPU: cpu_req = 1'b0;
          CLI_DMA: dma_req = 1'b0;
          default: ;
        endcase
      end else begin
        check_eq({tag, ".ack_off"}, {29'd0, vid_ack, cpu_ack, dma_ack}, 32'd0);
      end
    end
  endtask

  initial begin
    logic          ack_seen;
    logic          idle;
    logic [AW-1:0] exp_a;

    repeat (4) @(negedge clk_64);
    check_eq("rst.oe", {31'd0, mem_oe}, 32'd0);
    check_eq("rst.we", {31'd0, mem_we}, 32'd0);
    check_eq("rst.addr", {8'd0, mem_addr}, 32'd0);
    check_eq("rst.ds", {30'd0, mem_ds}, 32'd0);
    check_eq("rst.din", {16'd0, mem_din}, 32'd0);
    check_eq("rst.acks", {29'd0, vid_ack, cpu_ack, dma_ack}, 32'd0);
    check_eq("rst.rdata", {16'd0, rdata}, 32'd0);
    reset = 1'b0;

    // Video-only read: 0x1234 ^ 0xACDB = 0xBEEF
    wait_ph(3'd3);
    vid_req = 1'b1; vid_addr = 24'h001234;
    run_slot("vid_rd", CLI_VID, 1'b0, 24'h001234, 2'b11, 16'h0000, 1'b0);
    check_eq("vid_rd.literal", {16'd0, 16'h1234 ^ c_MEM_KEY}, 32'h0000BEEF);

    // All three requesting at once: video, then CPU, then DMA in consecutive slots
    wait_ph(3'd3);
    vid_req = 1'b1; vid_addr = 24'h000010;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h000020; cpu_ds = 2'b01;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 24'h000030; dma_ds = 2'b10; dma_wdata = 16'h1357;
    run_slot("pri_vid", CLI_VID, 1'b0, 24'h000010, 2'b11, 16'h0000, 1'b0);
    run_slot("pri_cpu", CLI_CPU, 1'b0, 24'h000020, 2'b11, 16'h0000, 1'b0);
    run_slot("pri_dma", CLI_DMA, 1'b1, 24'h000030, 2'b10, 16'h1357, 1'b0);

    // CPU write
    wait_ph(3'd3);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 24'h00ABCD; cpu_ds = 2'b01; cpu_wdata = 16'h5A5A;
    run_slot("cpu_wr", CLI_CPU, 1'b1, 24'h00ABCD, 2'b01, 16'h5A5A, 1'b0);

    // Three idle slots, then a request withdrawn before the grant edge
    run_slot("idle0", CLI_NONE, 1'b0, '0, 2'b00, 16'h0000, 1'b0);
    run_slot("idle1", CLI_NONE, 1'b0, '0, 2'b00, 16'h0000, 1'b0);
    run_slot("idle2", CLI_NONE, 1'b0, '0, 2'b00, 16'h0000, 1'b0);
    wait_ph(3'd3);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h000055;
    wait_ph(3'd5);
    cpu_req = 1'b0;
    run_slot("withdrawn", CLI_NONE, 1'b0, '0, 2'b00, 16'h0000, 1'b0);

    // Reset at ph2 of a granted CPU read
    wait_ph(3'd3);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h000777;
    wait_ph(3'd0);
    check_eq("rst_mid.granted_oe", {31'd0, mem_oe}, 32'd1);
    check_eq("rst_mid.granted_addr", {8'd0, mem_addr}, 32'h00000777);
    wait_ph(3'd2);
    reset = 1'b1; cpu_req = 1'b0;
    @(negedge clk_64);
    check_eq("rst_mid.oe", {31'd0, mem_oe}, 32'd0);
    check_eq("rst_mid.we", {31'd0, mem_we}, 32'd0);
    check_eq("rst_mid.addr", {8'd0, mem_addr}, 32'd0);
    check_eq("rst_mid.ds", {30'd0, mem_ds}, 32'd0);
    check_eq("rst_mid.din", {16'd0, mem_din}, 32'd0);
    check_eq("rst_mid.rdata", {16'd0, rdata}, 32'd0);
    ack_seen = cpu_ack;
    repeat (2) @(negedge clk_64);
    reset = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk_64);
      ack_seen = ack_seen | cpu_ack | vid_ack | dma_ack;
    end
    check_eq("rst_mid.no_ack", {31'd0, ack_seen}, 32'd0);

    // Phase realigned after reset: ack must land on the reference ph6
    wait_ph(3'd3);
    vid_req = 1'b1; vid_addr = 24'h0000AA;
    run_slot("post_rst_vid", CLI_VID, 1'b0, 24'h0000AA, 2'b11, 16'h0000, 1'b0);

    // Continuous video with a fresh address after every ack
    wait_ph(3'd3);
    vid_req = 1'b1; vid_addr = 24'h000100;
    exp_a = 24'h000100;
    for (int s = 0; s < 8; s++) begin
`ifdef SDRAM_ARB_REFRESH_SLOT_EN
      idle = ((s % REFRESH_INTERVAL) == (REFRESH_INTERVAL - 1));
`else
      idle = 1'b0;
`endif
      if (idle)
        run_slot("b2b_idle", CLI_NONE, 1'b0, '0, 2'b00, 16'h0000, 1'b1);
      else begin
        run_slot("b2b_vid", CLI_VID, 1'b0, exp_a, 2'b11, 16'h0000, 1'b1);
        exp_a = exp_a + 1'b1;
      end
    end
    vid_req = 1'b0;
    check_eq("b2b.final_addr", {8'd0, vid_addr}, {8'd0, exp_a});

    repeat (4) @(negedge clk_64);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
`default_nettype wire
